// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for a byte-addressed,
// word-wide memory port. Sub-word stores are done as read-modify-write because
// the port always writes four bytes.
module load_store_unit #(
   parameter int MEM_DEPTH      = 4096,
   parameter int REGISTER_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [2:0]                req_funct3,
   input  logic [REGISTER_WIDTH-1:0] req_address,
   input  logic [REGISTER_WIDTH-1:0] req_wdata,
   output logic                      rsp_valid,
   output logic [REGISTER_WIDTH-1:0] rsp_rdata,
   output logic                      rsp_error,
   output logic [REGISTER_WIDTH-1:0] mem_address,
   output logic                      mem_write_en,
   output logic [REGISTER_WIDTH-1:0] mem_write_data,
   input  logic [REGISTER_WIDTH-1:0] mem_read_data
);

   localparam logic [REGISTER_WIDTH-1:0] ADDR_MAX = REGISTER_WIDTH'(MEM_DEPTH - 4);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

   state_t                      state_q, state_d;
   logic [REGISTER_WIDTH-1:0]   addr_q, addr_d;
   logic [2:0]                  funct3_q, funct3_d;
   logic                        write_q, write_d;
   logic [REGISTER_WIDTH-1:0]   wdata_q, wdata_d;
   logic [REGISTER_WIDTH-1:0]   r_q, r_d;
   logic [REGISTER_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                        rsp_error_q, rsp_error_d;

   logic f3_illegal, misaligned, out_of_range, req_err;

   // Memory byte address+0 sits in the top byte of the read word, so a load
   // reassembles the little-endian value from the byte lanes in reverse.
   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [31:0] r);
      logic [7:0] b0, b1, b2, b3;
      b0 = r[31:24];
      b1 = r[23:16];
      b2 = r[15:8];
      b3 = r[7:0];
      case (f3[1:0])
         2'b00:   load_extract = f3[2] ? {24'h0, b0} : {{24{b0[7]}}, b0};
         2'b01:   load_extract = f3[2] ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
         default: load_extract = {b3, b2, b1, b0};
      endcase
   endfunction

   // Request legality is judged on the live request, at the accepting edge.
   assign f3_illegal   = req_write ? (req_funct3 > 3'b010)
                                   : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
   assign misaligned   = (req_funct3[1:0] == 2'b01 && req_address[0])
                      || (req_funct3[1:0] == 2'b10 && req_address[1:0] != 2'b00);
   assign out_of_range = req_address > ADDR_MAX;
   assign req_err      = f3_illegal || misaligned || out_of_range;

   // Next-state logic: capture on accept, sample memory in READ, and load the
   // response registers only on the edge that enters RESP (cleared otherwise).
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      funct3_d    = funct3_q;
      write_d     = write_q;
      wdata_d     = wdata_q;
      r_d         = r_q;
      rsp_rdata_d = '0;
      rsp_error_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d   = req_address;
               funct3_d = req_funct3;
               write_d  = req_write;
               wdata_d  = req_wdata;
               if (req_err) begin
                  state_d     = S_RESP;
                  rsp_error_d = 1'b1;
               end else if (req_write && req_funct3 == 3'b010) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            r_d = mem_read_data;
            if (write_q) begin
               state_d = S_WRITE;
            end else begin
               state_d     = S_RESP;
               rsp_rdata_d = load_extract(funct3_q, mem_read_data);
            end
         end
         S_WRITE: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Merge new store bytes into the word read back; untouched bytes are
   // written back in the write lane order of the port.
   always_comb begin
      case (funct3_q[1:0])
         2'b00:   mem_write_data = {r_q[7:0], r_q[15:8], r_q[23:16], wdata_q[7:0]};
         2'b01:   mem_write_data = {r_q[7:0], r_q[15:8], wdata_q[15:0]};
         default: mem_write_data = wdata_q;
      endcase
   end

   // State and capture registers; reset abandons any request in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         funct3_q    <= '0;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         r_q         <= '0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         funct3_q    <= funct3_d;
         write_q     <= write_d;
         wdata_q     <= wdata_d;
         r_q         <= r_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   assign req_ready    = (state_q == S_IDLE);
   assign rsp_valid    = (state_q == S_RESP) && !rst;
   assign mem_write_en = (state_q == S_WRITE) && !rst;
   assign rsp_rdata    = rsp_rdata_q;
   assign rsp_error    = rsp_error_q;
   assign mem_address  = addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table, reset/back-to-back sequences and
// a randomized phase checked against a byte-array reference model.
module tb_load_store_unit;
   localparam int DEPTH = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'b0;
   logic [31:0] req_address = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic [31:0] mem_address;
   logic        mem_write_en;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   int checks = 0;
   int failures = 0;

   load_store_unit #(.MEM_DEPTH(DEPTH), .REGISTER_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_address(req_address), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .mem_address(mem_address), .mem_write_en(mem_write_en),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   // attached memory: all writes (preload and DUT) in one process
   logic [7:0]  mem [DEPTH] = '{default: 8'h00};
   logic        pl_en = 1'b0;
   logic [11:0] pl_addr = 12'h0;
   logic [7:0]  pl_byte = 8'h0;
   int          wr_cnt = 0;
   logic [31:0] last_wd = 32'h0;

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_byte;
      if (mem_write_en) begin
         wr_cnt  <= wr_cnt + 1;
         last_wd <= mem_write_data;
         if (mem_address <= 32'(DEPTH - 4))
            for (int k = 0; k < 4; k++) mem[mem_address[11:0] + 12'(k)] <= mem_write_data[8*k +: 8];
      end
   end

   always_comb begin
      logic [11:0] a;
      a = mem_address[11:0];
      mem_read_data = 32'h0;
      if (mem_address <= 32'(DEPTH - 4))
         mem_read_data = {mem[a], mem[a + 12'd1], mem[a + 12'd2], mem[a + 12'd3]};
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic preload(input logic [11:0] a, input logic [7:0] b);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_byte = b;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // one full transaction; req_* are scrambled right after acceptance
   task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output int nwr, output logic [31:0] wdo);
      int guard = 0;
      int w0;
      while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_address = a; req_wdata = wd;
      w0 = wr_cnt;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_write = 1'($urandom); req_funct3 = 3'($urandom);
      req_address = $urandom; req_wdata = $urandom;
      lat = 1;
      while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
      if (!rsp_valid) begin
         lat = 99; rd = 32'hDEADBEEF; er = 1'bx;
      end else begin
         rd = rsp_rdata; er = rsp_error;
      end
      chk("mem_address_held", mem_address, a);
      @(negedge clk);
      chk("rsp_single_cycle", {31'h0, rsp_valid}, 32'h0);
      chk("rsp_rdata_idle_zero", rsp_rdata, 32'h0);
      nwr = wr_cnt - w0;
      wdo = last_wd;
   endtask

   // reference model: byte array plus RISC-V access rules
   logic [7:0] refmem [DEPTH];

   task automatic ref_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] rd, output logic er,
                             output int lat, output int nwr);
      int size;
      logic legal;
      logic [31:0] val;
      size  = 1 << f3[1:0];
      legal = w ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      er    = !(legal && (a % size) == 0 && a <= 32'(DEPTH - 4));
      rd = 32'h0; nwr = 0;
      if (er) begin
         lat = 1;
      end else if (!w) begin
         lat = 2;
         val = 32'h0;
         for (int k = 0; k < size; k++) val = val | (32'(refmem[a + k]) << (8 * k));
         if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'h1 << (8 * size)) - 32'h1);
         rd = val;
      end else begin
         lat = (size == 4) ? 2 : 3;
         nwr = 1;
         for (int k = 0; k < size; k++) refmem[a + k] = wd[8*k +: 8];
      end
   endtask

   typedef struct {
      logic        w;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      logic [31:0] exp_wd;
   } vec_t;

   vec_t vecs [12];

   initial begin
      logic [31:0] rd, wdo, erd;
      logic        er, eer;
      int          lat, nwr, elat, enwr, nmis;
      logic        rdy [7];
      logic        rv  [7];
      logic [31:0] rdv [7];

      vecs[0]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h84332211, 1'b0, 2, 32'h0};
      vecs[1]  = '{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF84, 1'b0, 2, 32'h0};
      vecs[2]  = '{1'b0, 3'b100, 32'h13, 32'h0,        32'h00000084, 1'b0, 2, 32'h0};
      vecs[3]  = '{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8433, 1'b0, 2, 32'h0};
      vecs[4]  = '{1'b0, 3'b101, 32'h12, 32'h0,        32'h00008433, 1'b0, 2, 32'h0};
      vecs[5]  = '{1'b1, 3'b000, 32'h11, 32'hAABBCCDD, 32'h0,        1'b0, 3, 32'h558433DD};
      vecs[6]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h8433DD11, 1'b0, 2, 32'h0};
      vecs[7]  = '{1'b1, 3'b001, 32'h11, 32'h12345678, 32'h0,        1'b1, 1, 32'h0};
      vecs[8]  = '{1'b1, 3'b010, 32'h12, 32'h12345678, 32'h0,        1'b1, 1, 32'h0};
      vecs[9]  = '{1'b0, 3'b001, 32'h13, 32'h0,        32'h0,        1'b1, 1, 32'h0};
      vecs[10] = '{1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 1, 32'h0};
      vecs[11] = '{1'b0, 3'b010, 32'(DEPTH - 2), 32'h0, 32'h0,       1'b1, 1, 32'h0};

      // reset state, with a request offered while reset is high
      req_valid = 1'b1; req_address = 32'h10; req_funct3 = 3'b010;
      @(negedge clk);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rsp_error", {31'h0, rsp_error}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_mem_write_en", {31'h0, mem_write_en}, 32'h0);
      chk("rst_mem_address", mem_address, 32'h0);
      chk("rst_mem_write_data", mem_write_data, 32'h0);
      @(negedge clk);
      req_valid = 1'b0; rst = 1'b0;
      @(negedge clk);
      chk("post_rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
      chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

      preload(12'h10, 8'h11); preload(12'h11, 8'h22); preload(12'h12, 8'h33); preload(12'h13, 8'h84);
      preload(12'h14, 8'h55); preload(12'h15, 8'h66); preload(12'h16, 8'h77); preload(12'h17, 8'h88);

      // directed vector table
      for (int i = 0; i < 12; i++) begin
         do_req(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, er, lat, nwr, wdo);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d_error", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         chk($sformatf("vec%0d_writes", i), 32'(nwr), (vecs[i].w && !vecs[i].exp_err) ? 32'h1 : 32'h0);
         if (vecs[i].w && !vecs[i].exp_err) chk($sformatf("vec%0d_wdata", i), wdo, vecs[i].exp_wd);
      end
      chk("mem_after_table", {mem[16], mem[17], mem[18], mem[19]}, 32'h11DD3384);
      chk("mem_after_table_14", {24'h0, mem[20]}, 32'h55);

      // reset while an SB sits in READ: no write, no response
      preload(12'h11, 8'h22);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_address = 32'h10; req_wdata = 32'hFF;
      nwr = wr_cnt;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("midrst_write_en", {31'h0, mem_write_en}, 32'h0);
      chk("midrst_ready", {31'h0, req_ready}, 32'h1);
      @(negedge clk);
      rst = 1'b0;
      lat = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (rsp_valid || !req_ready) lat++;
      end
      chk("midrst_quiet_after", 32'(lat), 32'h0);
      chk("midrst_no_write", 32'(wr_cnt - nwr), 32'h0);
      do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, nwr, wdo);
      chk("midrst_lw_rdata", rd, 32'h84332211);
      chk("midrst_lw_error", {31'h0, er}, 32'h0);

      // back-to-back loads with req_valid held high
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h10;
      @(posedge clk);
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         rdy[c] = req_ready; rv[c] = rsp_valid; rdv[c] = rsp_rdata;
         if (c == 0) req_address = 32'h14;
         if (c == 3) req_valid = 1'b0;
      end
      chk("b2b_ready", {25'h0, rdy[0], rdy[1], rdy[2], rdy[3], rdy[4], rdy[5], rdy[6]}, 32'b0010011);
      chk("b2b_rsp_valid", {25'h0, rv[0], rv[1], rv[2], rv[3], rv[4], rv[5], rv[6]}, 32'b0100100);
      chk("b2b_rdata0", rdv[1], 32'h84332211);
      chk("b2b_rdata1", rdv[4], 32'h88776655);

      // randomized phase against the reference model
      @(negedge clk);
      for (int i = 0; i < DEPTH; i++) refmem[i] = mem[i];
      for (int i = 0; i < 200; i++) begin
         logic        w;
         logic [2:0]  f3;
         logic [31:0] a, wd;
         w  = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 3) == 0) ? 32'(DEPTH - 10 + $urandom_range(0, 14))
                                          : 32'($urandom_range(0, 63));
         wd = $urandom;
         ref_access(w, f3, a, wd, erd, eer, elat, enwr);
         do_req(w, f3, a, wd, rd, er, lat, nwr, wdo);
         chk($sformatf("rnd%0d_rdata", i), rd, erd);
         chk($sformatf("rnd%0d_error", i), {31'h0, er}, {31'h0, eer});
         chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(elat));
         chk($sformatf("rnd%0d_writes", i), 32'(nwr), 32'(enwr));
      end
      nmis = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== refmem[i]) nmis++;
      chk("rnd_mem_contents", 32'(nmis), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // hard time limit so the bench always ends
   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
